uart_msg_scheduler: RTL and testbench



---
 rtl/uart_sched_pkg.sv | 35 +++
 rtl/uart_msg_scheduler_rr_arbiter.sv | 29 ++
 rtl/uart_msg_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_uart_msg_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared definitions for the UART message scheduler: header layout,
// FSM state encoding and length limits.
package uart_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARB   = 3'd1,
      S_START = 3'd2,
      S_LATCH = 3'd3,
      S_HDR   = 3'd4,
      S_DATA  = 3'd5,
      S_DONE  = 3'd6
   } sched_state_e;

   // header word layout: {ch[3:0], pad, 3'b000, len[7:0]}
   localparam int HDR_CH_HI   = 15;
   localparam int HDR_CH_LO   = 12;
   localparam int HDR_PAD_BIT = 11;
   localparam int HDR_LEN_HI  = 7;
   localparam int HDR_LEN_LO  = 0;

   localparam logic [7:0] LEN_MAX = 8'hFF;

   function automatic logic [15:0] make_header(input logic [3:0] ch,
                                               input logic       pad,
                                               input logic [7:0] len);
      logic [15:0] h;
      h = '0;
      h[HDR_CH_HI:HDR_CH_LO]   = ch;
      h[HDR_PAD_BIT]           = pad;
      h[HDR_LEN_HI:HDR_LEN_LO] = len;
      return h;
   endfunction

endpackage

// File: rtl/uart_msg_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo N_CH.
module rr_arbiter #(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   output logic [CH_W-1:0] gnt_idx,
   output logic            gnt_vld
);

   // scan N_CH positions starting at ptr, keep the first hit
   always_comb begin
      int idx;
      idx     = 0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!gnt_vld && req[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = CH_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_msg_scheduler.sv
// Round-robin scheduler sharing one 16-bit packet stream between N_CH
// UART channel buffers. Each packet is a header word followed by len
// data words read one at a time from the granted channel.
//
// state | meaning
// IDLE  | no work; waiting for any GFM bit
// ARB   | pick next channel round-robin from ptr, latch CUR_CH
// START | one-cycle MSG_START to the granted channel
// LATCH | capture len/pad from the channel, load header into output reg
// HDR   | header word offered with SOP (EOP too when len == 0)
// DATA  | read words one at a time, offer each, EOP/PAD on the last
// DONE  | advance pointer past the served channel
module uart_msg_scheduler
   import uart_sched_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int CH_W = 2
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [N_CH-1:0]      GFM,
   output logic [N_CH-1:0]      MSG_START,
   output logic [N_CH-1:0]      RD_REQ,
   input  logic [16*N_CH-1:0]   FIFO_Q,
   input  logic [8*N_CH-1:0]    MSG_LEN,
   input  logic [N_CH-1:0]      PARITY_IN,
   output logic [15:0]          OUT_DATA,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic                 OUT_SOP,
   output logic                 OUT_EOP,
   output logic                 OUT_PAD,
   output logic                 BUSY,
   output logic [CH_W-1:0]      CUR_CH
);

   sched_state_e    state_q, state_d;
   logic [CH_W-1:0] ptr_q, ptr_d;
   logic [CH_W-1:0] cur_ch_q, cur_ch_d;
   logic [7:0]      len_q, len_d;
   logic [7:0]      rem_q, rem_d;
   logic            pad_q, pad_d;
   logic            rd_pend_q, rd_pend_d;
   logic            out_valid_q, out_valid_d;
   logic [15:0]     out_data_q, out_data_d;
   logic            out_sop_q, out_sop_d;
   logic            out_eop_q, out_eop_d;
   logic            out_pad_q, out_pad_d;

   logic [CH_W-1:0] arb_idx;
   logic            arb_vld;
   logic [15:0]     fifo_sel;
   logic [7:0]      len_sel;
   logic            par_sel;
   logic [3:0]      ch_ext;
   logic            accept;
   logic [N_CH-1:0] msg_start_o;
   logic [N_CH-1:0] rd_req_o;

   rr_arbiter #(
      .N_CH (N_CH),
      .CH_W (CH_W)
   ) u_arb (
      .req     (GFM),
      .ptr     (ptr_q),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   assign accept = out_valid_q & OUT_READY;

   // select the granted channel's word, length and parity
   always_comb begin
      fifo_sel = '0;
      len_sel  = '0;
      par_sel  = 1'b0;
      ch_ext   = '0;
      ch_ext[CH_W-1:0] = cur_ch_q;
      for (int c = 0; c < N_CH; c++) begin
         if (cur_ch_q == CH_W'(c)) begin
            fifo_sel = FIFO_Q[16*c +: 16];
            len_sel  = MSG_LEN[8*c +: 8];
            par_sel  = PARITY_IN[c];
         end
      end
   end

   // next-state and one-hot strobes
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cur_ch_d    = cur_ch_q;
      len_d       = len_q;
      rem_d       = rem_q;
      pad_d       = pad_q;
      rd_pend_d   = rd_pend_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sop_d   = out_sop_q;
      out_eop_d   = out_eop_q;
      out_pad_d   = out_pad_q;
      msg_start_o = '0;
      rd_req_o    = '0;

      case (state_q)
         S_IDLE: begin
            if (|GFM) state_d = S_ARB;
         end

         S_ARB: begin
            if (arb_vld) begin
               cur_ch_d = arb_idx;
               state_d  = S_START;
            end else begin
               state_d  = S_IDLE;
            end
         end

         S_START: begin
            for (int c = 0; c < N_CH; c++)
               msg_start_o[c] = (cur_ch_q == CH_W'(c));
            state_d = S_LATCH;
         end

         S_LATCH: begin
            len_d       = len_sel;
            pad_d       = par_sel;
            rem_d       = len_sel;
            rd_pend_d   = 1'b0;
            out_valid_d = 1'b1;
            out_data_d  = make_header(ch_ext, par_sel, len_sel);
            out_sop_d   = 1'b1;
            out_eop_d   = (len_sel == 8'd0);
            out_pad_d   = 1'b0;
            state_d     = S_HDR;
         end

         S_HDR: begin
            if (accept) begin
               out_valid_d = 1'b0;
               out_sop_d   = 1'b0;
               out_eop_d   = 1'b0;
               state_d     = (len_q == 8'd0) ? S_DONE : S_DATA;
            end
         end

         S_DATA: begin
            if (accept) begin
               out_valid_d = 1'b0;
               out_eop_d   = 1'b0;
               out_pad_d   = 1'b0;
               if (out_eop_q) state_d = S_DONE;
            end
            // one read in flight at most, and only into a free output slot
            if (!rd_pend_q && (!out_valid_q || accept) && (rem_q != 8'd0)) begin
               for (int c = 0; c < N_CH; c++)
                  rd_req_o[c] = (cur_ch_q == CH_W'(c));
               rem_d     = rem_q - 8'd1;
               rd_pend_d = 1'b1;
            end
            if (rd_pend_q) begin
               rd_pend_d   = 1'b0;
               out_valid_d = 1'b1;
               out_data_d  = fifo_sel;
               out_sop_d   = 1'b0;
               out_eop_d   = (rem_q == 8'd0);
               out_pad_d   = (rem_q == 8'd0) & pad_q;
            end
         end

         S_DONE: begin
            ptr_d       = (cur_ch_q == CH_W'(N_CH - 1)) ? '0 : cur_ch_q + 1'b1;
            out_valid_d = 1'b0;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_pad_d   = 1'b0;
            rd_pend_d   = 1'b0;
            state_d     = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cur_ch_q    <= '0;
         len_q       <= '0;
         rem_q       <= '0;
         pad_q       <= 1'b0;
         rd_pend_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         out_pad_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cur_ch_q    <= cur_ch_d;
         len_q       <= len_d;
         rem_q       <= rem_d;
         pad_q       <= pad_d;
         rd_pend_q   <= rd_pend_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         out_pad_q   <= out_pad_d;
      end
   end

   assign MSG_START = msg_start_o;
   assign RD_REQ    = rd_req_o;
   assign OUT_DATA  = out_data_q;
   assign OUT_VALID = out_valid_q;
   assign OUT_SOP   = out_sop_q;
   assign OUT_EOP   = out_eop_q;
   assign OUT_PAD   = out_pad_q;
   assign BUSY      = (state_q != S_IDLE);
   assign CUR_CH    = cur_ch_q;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Bench for uart_msg_scheduler: channel buffer model plus a table of
// packets with hand-computed headers, then an abort-by-reset sequence.
module tb_uart_msg_scheduler;

   localparam int N_CH = 4;
   localparam int CH_W = 2;
   localparam int MAXW = 512;

   logic                CLK = 1'b0;
   logic                RST = 1'b0;
   logic [N_CH-1:0]     GFM;
   logic [N_CH-1:0]     MSG_START;
   logic [N_CH-1:0]     RD_REQ;
   logic [16*N_CH-1:0]  FIFO_Q;
   logic [8*N_CH-1:0]   MSG_LEN;
   logic [N_CH-1:0]     PARITY_IN;
   logic [15:0]         OUT_DATA;
   logic                OUT_VALID;
   logic                OUT_READY;
   logic                OUT_SOP;
   logic                OUT_EOP;
   logic                OUT_PAD;
   logic                BUSY;
   logic [CH_W-1:0]     CUR_CH;

   always #5 CLK = ~CLK;

   uart_msg_scheduler #(.N_CH(N_CH), .CH_W(CH_W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .GFM       (GFM),
      .MSG_START (MSG_START),
      .RD_REQ    (RD_REQ),
      .FIFO_Q    (FIFO_Q),
      .MSG_LEN   (MSG_LEN),
      .PARITY_IN (PARITY_IN),
      .OUT_DATA  (OUT_DATA),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .OUT_SOP   (OUT_SOP),
      .OUT_EOP   (OUT_EOP),
      .OUT_PAD   (OUT_PAD),
      .BUSY      (BUSY),
      .CUR_CH    (CUR_CH)
   );

   // ---------------- channel buffer model ----------------
   logic [15:0]     fifo_r [N_CH];
   logic [7:0]      len_r  [N_CH];
   logic            par_r  [N_CH];
   int              widx   [N_CH] = '{default: 0};
   logic [N_CH-1:0] gfm_r = '0;
   logic [7:0]      cfg_len [N_CH] = '{default: 8'd0};
   logic            cfg_par [N_CH] = '{default: 1'b0};
   logic [N_CH-1:0] gfm_load_val = '0;
   logic            gfm_load = 1'b0;

   function automatic logic [15:0] word_of(input logic [3:0] c, input logic [7:0] i);
      return {c, 4'h5, i};
   endfunction

   assign GFM = gfm_r;

   always_comb begin
      FIFO_Q    = '0;
      MSG_LEN   = '0;
      PARITY_IN = '0;
      for (int c = 0; c < N_CH; c++) begin
         FIFO_Q[16*c +: 16] = fifo_r[c];
         MSG_LEN[8*c +: 8]  = len_r[c];
         PARITY_IN[c]       = par_r[c];
      end
   end

   always @(posedge CLK) begin
      logic [N_CH-1:0] nxt;
      nxt = gfm_r | (gfm_load ? gfm_load_val : '0);
      for (int c = 0; c < N_CH; c++) begin
         if (MSG_START[c]) begin
            nxt[c]  = 1'b0;
            len_r[c] <= cfg_len[c];
            par_r[c] <= cfg_par[c];
            widx[c]  <= 0;
         end
         if (RD_REQ[c]) begin
            fifo_r[c] <= word_of(4'(c), 8'(widx[c]));
            widx[c]   <= widx[c] + 1;
         end
      end
      gfm_r <= nxt;
   end

   // ---------------- output monitor ----------------
   logic [18:0]     acc_w  [MAXW];
   logic [CH_W-1:0] acc_ch [MAXW];
   int              wr = 0;
   int              ms_cnt [N_CH] = '{default: 0};
   int              rd_cnt [N_CH] = '{default: 0};
   int              viol = 0;
   logic            prev_pend = 1'b0;
   logic [18:0]     prev_word = '0;

   always @(negedge CLK) begin
      if (!RST) begin
         prev_pend = 1'b0;
      end else begin
         if ($countones(MSG_START) > 1 || $countones(RD_REQ) > 1) viol++;
         if ((RD_REQ & ~(N_CH'(1) << CUR_CH)) != '0) viol++;
         if ((MSG_START & ~(N_CH'(1) << CUR_CH)) != '0) viol++;
         if (|RD_REQ && OUT_VALID && !OUT_READY) viol++;
         if (prev_pend && (!OUT_VALID || {OUT_SOP, OUT_EOP, OUT_PAD, OUT_DATA} != prev_word)) viol++;
         for (int c = 0; c < N_CH; c++) begin
            if (MSG_START[c]) ms_cnt[c]++;
            if (RD_REQ[c])    rd_cnt[c]++;
         end
         if (OUT_VALID && OUT_READY && wr < MAXW) begin
            acc_w[wr]  = {OUT_SOP, OUT_EOP, OUT_PAD, OUT_DATA};
            acc_ch[wr] = CUR_CH;
            wr++;
         end
         prev_pend = OUT_VALID && !OUT_READY;
         prev_word = {OUT_SOP, OUT_EOP, OUT_PAD, OUT_DATA};
      end
   end

   // ---------------- stimulus and checking ----------------
   typedef struct {
      logic [3:0]  gfm;
      int          ch;
      logic [7:0]  len;
      logic        par;
      bit          rnd;
      logic [15:0] hdr;
   } vec_t;

   vec_t vecs [8];
   int   n_checks = 0;
   int   n_fails  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic arm(input logic [N_CH-1:0] v);
      gfm_load_val = v;
      gfm_load     = 1'b1;
      step();
      gfm_load     = 1'b0;
   endtask

   task automatic wait_words(input int target, input bit rnd);
      int cyc;
      cyc = 0;
      while (wr < target && cyc < 500) begin
         OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         step();
         cyc++;
      end
      OUT_READY = 1'b1;
   endtask

   initial begin
      int base, need, ms0, rd_tot0, viol0;
      int rd0 [N_CH];
      logic last;

      vecs[0] = '{4'b0010, 1, 8'd3, 1'b0, 1'b0, 16'h1003};
      vecs[1] = '{4'b1011, 3, 8'd1, 1'b0, 1'b0, 16'h3001};
      vecs[2] = '{4'b0000, 0, 8'd2, 1'b1, 1'b0, 16'h0802};
      vecs[3] = '{4'b0000, 1, 8'd1, 1'b0, 1'b0, 16'h1001};
      vecs[4] = '{4'b0100, 2, 8'd2, 1'b1, 1'b0, 16'h2802};
      vecs[5] = '{4'b0001, 0, 8'd0, 1'b0, 1'b0, 16'h0000};
      vecs[6] = '{4'b1000, 3, 8'd5, 1'b0, 1'b1, 16'h3005};
      vecs[7] = '{4'b0010, 1, 8'd1, 1'b1, 1'b0, 16'h1801};

      OUT_READY = 1'b1;
      RST = 1'b0;
      repeat (3) step();
      check("reset_out", {OUT_VALID, OUT_SOP, OUT_EOP, OUT_PAD, OUT_DATA}, 0);
      check("reset_ctl", {BUSY, CUR_CH, MSG_START, RD_REQ}, 0);
      RST = 1'b1;
      step();
      check("idle_busy", {31'd0, BUSY}, 0);

      for (int i = 0; i < 8; i++) begin
         base = wr;
         for (int c = 0; c < N_CH; c++) rd0[c] = rd_cnt[c];
         ms0   = ms_cnt[vecs[i].ch];
         viol0 = viol;
         rd_tot0 = 0;
         for (int c = 0; c < N_CH; c++) rd_tot0 += rd_cnt[c];
         if (vecs[i].gfm != 0) begin
            for (int j = i; j < 8 && (j == i || vecs[j].gfm == 0); j++) begin
               cfg_len[vecs[j].ch] = vecs[j].len;
               cfg_par[vecs[j].ch] = vecs[j].par;
            end
            arm(vecs[i].gfm);
         end
         need = int'(vecs[i].len) + 1;
         wait_words(base + need, vecs[i].rnd);
         check($sformatf("v%0d_words", i), wr - base, need);
         check($sformatf("v%0d_hdr", i), acc_w[base][15:0], vecs[i].hdr);
         check($sformatf("v%0d_hdr_flags", i), acc_w[base][18:16],
               {1'b1, (vecs[i].len == 8'd0), 1'b0});
         check($sformatf("v%0d_grant", i), acc_ch[base], vecs[i].ch);
         for (int k = 0; k < int'(vecs[i].len); k++) begin
            last = (k == int'(vecs[i].len) - 1);
            check($sformatf("v%0d_d%0d", i, k), acc_w[base+1+k][15:0],
                  word_of(4'(vecs[i].ch), 8'(k)));
            check($sformatf("v%0d_d%0d_flags", i, k), acc_w[base+1+k][18:16],
                  {1'b0, last, last & vecs[i].par});
         end
         need = 0;
         for (int c = 0; c < N_CH; c++) need += rd_cnt[c];
         check($sformatf("v%0d_rd_total", i), need - rd_tot0, vecs[i].len);
         check($sformatf("v%0d_rd_ch", i), rd_cnt[vecs[i].ch] - rd0[vecs[i].ch], vecs[i].len);
         check($sformatf("v%0d_msg_start", i), ms_cnt[vecs[i].ch] - ms0, 1);
         check($sformatf("v%0d_protocol", i), viol - viol0, 0);
      end

      // abort a packet with reset while data is flowing
      base = wr;
      cfg_len[3] = 8'd4;
      cfg_par[3] = 1'b0;
      arm(4'b1000);
      wait_words(base + 2, 1'b0);
      check("abort_progress", wr - base, 2);
      RST = 1'b0;
      #1;
      check("abort_out", {OUT_VALID, OUT_SOP, OUT_EOP, OUT_PAD, OUT_DATA}, 0);
      check("abort_ctl", {BUSY, CUR_CH, MSG_START, RD_REQ}, 0);
      repeat (2) step();
      RST = 1'b1;
      step();
      check("post_reset_idle", {BUSY, CUR_CH}, 0);

      // pointer back at 0: with ch1 and ch3 pending, ch1 wins
      base = wr;
      cfg_len[1] = 8'd0;
      cfg_par[1] = 1'b0;
      arm(4'b1010);
      wait_words(base + 1, 1'b0);
      check("post_reset_words", wr - base, 1);
      check("post_reset_hdr", acc_w[base], {3'b110, 16'h1000});
      check("post_reset_grant", acc_ch[base], 1);
      repeat (30) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
